// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions used by the instruction-memory loader.
// Contents:
//   IMEM_DEPTH     - instruction-memory capacity in 32-bit words
//   INSTR_W        - instruction word width in bits
//   loader_state_t - loader FSM states (LOAD, DONE, ERROR)
package mips32_pkg;

    localparam int IMEM_DEPTH = 512;
    localparam int INSTR_W    = 32;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DONE  = 2'd1,
        ERROR = 2'd2
    } loader_state_t;

endpackage

// File: rtl/mips32_word_packer.sv
// Packs a byte stream into big-endian 32-bit words.
// The first byte of a word lands in [31:24]. A word is presented
// combinationally on the cycle its 4th byte, or a byte marked last, is
// accepted. A short final word has its unfilled low bytes set to zero.
// Ports:
//   clk_1, rst  - clock and synchronous active-high reset
//   clear       - restart packing at byte 0 (fresh load)
//   accept      - byte_in/last are consumed this cycle
//   byte_in     - program byte
//   last        - byte_in is the final byte of the program
//   word_valid  - word is complete this cycle
//   word        - assembled (zero-padded) word
module mips32_word_packer
    import mips32_pkg::*;
(
    input  logic               clk_1,
    input  logic               rst,
    input  logic               clear,
    input  logic               accept,
    input  logic [7:0]         byte_in,
    input  logic               last,
    output logic               word_valid,
    output logic [INSTR_W-1:0] word
);

    logic [1:0]  byte_idx;
    // Earlier bytes of the current word; the most recent byte sits in [7:0].
    logic [23:0] shreg;

    assign word_valid = accept && ((byte_idx == 2'd3) || last);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        word = '0;
        case (byte_idx)
            2'd0: word = {byte_in, 24'h0};
            2'd1: word = {shreg[7:0], byte_in, 16'h0};
            2'd2: word = {shreg[15:0], byte_in, 8'h0};
            default: word = {shreg, byte_in};
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk_1) begin
        if (rst || clear) begin
            byte_idx <= 2'd0;
            shreg    <= '0;
        end else if (accept) begin
            byte_idx <= word_valid ? 2'd0 : byte_idx + 2'd1;
            shreg    <= {shreg[15:0], byte_in};
        end
    end

endmodule

// File: rtl/mips32_imem_loader.sv
// Loads a MIPS32 program from a byte stream into instruction memory and
// holds the core in reset until the load completes.
// Ports:
//   clk_1, rst           - clock and synchronous active-high reset
//   in_valid/in_ready    - byte stream handshake
//   in_data, in_last     - program byte and end-of-program marker
//   start                - begin a fresh load (only from DONE or ERROR)
//   imem_we/addr/wdata   - registered one-cycle write to instruction memory
//   core_rst             - holds the core in reset while 1
//   done, err_overflow   - FSM is in DONE / ERROR
//   word_count           - words written since the load began
module mips32_imem_loader
    import mips32_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = 9
) (
    input  logic               clk_1,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    input  logic               start,
    output logic               imem_we,
    output logic [AW-1:0]      imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               core_rst,
    output logic               done,
    output logic               err_overflow,
    output logic [AW:0]        word_count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE        = {{AW{1'b0}}, 1'b1};

    loader_state_t      state;
    logic               accept;
    logic               restart;
    logic               word_valid;
    logic [INSTR_W-1:0] word;

    assign in_ready = (state == LOAD);
    assign accept   = in_valid && in_ready;
    assign restart  = start && (state != LOAD);

    // start is decoded combinationally so the core goes back into reset on
    // the very cycle the reload is requested, not one cycle later.
    assign core_rst     = (state != DONE) || restart;
    assign done         = (state == DONE) && !restart;
    assign err_overflow = (state == ERROR);

    mips32_word_packer u_packer (
        .clk_1      (clk_1),
        .rst        (rst),
        .clear      (restart),
        .accept     (accept),
        .byte_in    (in_data),
        .last       (in_last),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk_1) begin
        if (rst) begin
            state      <= LOAD;
            word_count <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        // Memory is full: drop the byte and never wrap the address.
                        if (word_count == FULL_COUNT) begin
                            state <= ERROR;
                        end else begin
                            if (word_valid) begin
                                imem_we    <= 1'b1;
                                imem_addr  <= word_count[AW-1:0];
                                imem_wdata <= word;
                                word_count <= word_count + ONE;
                            end
                            if (in_last) begin
                                state <= DONE;
                            end
                        end
                    end
                end
                DONE, ERROR: begin
                    if (start) begin
                        state      <= LOAD;
                        word_count <= '0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_mips32_imem_loader.sv
module tb_mips32_imem_loader;
    import mips32_pkg::*;

    localparam int DEPTH = 512;
    localparam int AW    = 9;

    logic          clk_1 = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          in_last;
    logic          start;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst;
    logic          done;
    logic          err_overflow;
    logic [AW:0]   word_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];

    mips32_imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_1        (clk_1),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .start        (start),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst     (core_rst),
        .done         (done),
        .err_overflow (err_overflow),
        .word_count   (word_count)
    );

    always #5 clk_1 = ~clk_1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int addr, input logic [31:0] data);
        wr_t w;
        w.addr = 32'(addr);
        w.data = data;
        exp_q.push_back(w);
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    always @(negedge clk_1) begin
        if (!rst && imem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%08h expected none",
                         imem_addr, imem_wdata);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), w.addr);
                check("wr_data", imem_wdata, w.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk_1);
        #1;
    endtask

    // One byte offered for exactly one cycle; inputs are left asserted so
    // consecutive calls stream back-to-back.
    task automatic drive(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [7:0] b [4];

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        start    = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset values
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err_overflow), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);

        // Scenario 1: one full word with last on byte 4
        push_exp(0, 32'h2001000A);
        drive(8'h20, 1'b0);
        drive(8'h01, 1'b0);
        drive(8'h00, 1'b0);
        drive(8'h0A, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("s1_done", 32'(done), 32'd1);
        check("s1_core_rst", 32'(core_rst), 32'd0);
        check("s1_word_count", 32'(word_count), 32'd1);
        check("s1_in_ready", 32'(in_ready), 32'd0);
        idle(2);
        check("s1_no_extra_wc", 32'(word_count), 32'd1);

        // Scenario 5: start in DONE
        start = 1'b1;
        #1;
        check("s5_core_rst_same", 32'(core_rst), 32'd1);
        check("s5_done_same", 32'(done), 32'd0);
        tick();
        start = 1'b0;
        check("s5_in_ready", 32'(in_ready), 32'd1);
        check("s5_word_count", 32'(word_count), 32'd0);
        check("s5_core_rst", 32'(core_rst), 32'd1);

        // Scenario 2: 6 bytes -> padded second word
        push_exp(0, 32'h11121314);
        push_exp(1, 32'h15160000);
        for (int i = 0; i < 6; i++) drive(8'(8'h11 + i), i == 5);
        idle(1);
        check("s2_word_count", 32'(word_count), 32'd2);
        check("s2_done", 32'(done), 32'd1);
        pulse_start();

        // Scenario 6: in_valid toggling, start in LOAD ignored
        push_exp(0, 32'hA0A1A2A3);
        push_exp(1, 32'hA4A5A6A7);
        for (int i = 0; i < 8; i++) begin
            if (i == 5) start = 1'b1;
            drive(8'(8'hA0 + i), i == 7);
            start = 1'b0;
            if (i == 5) check("s6_start_ignored_wc", 32'(word_count), 32'd1);
            idle(1);
        end
        check("s6_word_count", 32'(word_count), 32'd2);
        check("s6_done", 32'(done), 32'd1);
        pulse_start();

        // Scenario 4: reset mid-word discards partial word 3
        for (int w = 0; w < 3; w++) begin
            push_exp(w, {8'(8'h40 + 4*w), 8'(8'h41 + 4*w), 8'(8'h42 + 4*w), 8'(8'h43 + 4*w)});
            for (int j = 0; j < 4; j++) drive(8'(8'h40 + 4*w + j), 1'b0);
        end
        drive(8'h50, 1'b0);
        drive(8'h51, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s4_word_count", 32'(word_count), 32'd0);
        check("s4_imem_we", 32'(imem_we), 32'd0);
        check("s4_in_ready", 32'(in_ready), 32'd1);
        push_exp(0, 32'hC0C1C2C3);
        for (int j = 0; j < 4; j++) drive(8'(8'hC0 + j), j == 3);
        idle(1);
        check("s4_after_wc", 32'(word_count), 32'd1);
        pulse_start();

        // Scenario 3: fill memory, then one extra byte overflows
        for (int k = 0; k < DEPTH; k++) begin
            for (int j = 0; j < 4; j++) b[j] = 8'(4*k + j);
            push_exp(k, {b[0], b[1], b[2], b[3]});
        end
        for (int i = 0; i < 4*DEPTH; i++) drive(8'(i), 1'b0);
        check("s3_full_wc", 32'(word_count), 32'(DEPTH));
        check("s3_full_in_ready", 32'(in_ready), 32'd1);
        drive(8'hEE, 1'b0);
        in_valid = 1'b0;
        check("s3_err", 32'(err_overflow), 32'd1);
        check("s3_in_ready", 32'(in_ready), 32'd0);
        check("s3_core_rst", 32'(core_rst), 32'd1);
        check("s3_done", 32'(done), 32'd0);
        check("s3_wc_held", 32'(word_count), 32'(DEPTH));
        idle(2);

        // start from ERROR returns to LOAD
        pulse_start();
        check("err_restart_in_ready", 32'(in_ready), 32'd1);
        check("err_restart_err", 32'(err_overflow), 32'd0);
        check("err_restart_wc", 32'(word_count), 32'd0);

        idle(2);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
